button_debouncer: RTL and testbench

//   Conditions raw push-button inputs before they reach the LED logic stage.
//   Per button: 2-FF synchronizer, counter-based debounce filter, clean level

---
 rtl/button_debouncer.sv | 89 ++++++++
 tb/tb_button_debouncer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Per-button 2-FF synchronizer, counter debounce filter, clean level and 1-cycle rise/fall pulses.
// Optional per-button 8-bit press counters when BTN_PRESS_COUNT_EN is defined.
module button_debouncer #(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_BTNS-1:0]   i_btn,
  output logic [NUM_BTNS-1:0]   o_btn,
  output logic [NUM_BTNS-1:0]   o_rise,
  output logic [NUM_BTNS-1:0]   o_fall
`ifdef BTN_PRESS_COUNT_EN
  ,
  output logic [8*NUM_BTNS-1:0] o_press_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTNS-1:0]            sync1_q, sync2_q;
  logic [NUM_BTNS-1:0]            btn_q, btn_d;
  logic [NUM_BTNS-1:0]            rise_q, rise_d;
  logic [NUM_BTNS-1:0]            fall_q, fall_d;
  logic [NUM_BTNS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    btn_d  = btn_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int n = 0; n < NUM_BTNS; n++) begin
      if (sync2_q[n] == btn_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_MAX) begin
        // Input has disagreed with the accepted level for long enough: accept it.
        btn_d[n]  = sync2_q[n];
        rise_d[n] = sync2_q[n];
        fall_d[n] = ~sync2_q[n];
        cnt_d[n]  = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_btn  = btn_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

`ifdef BTN_PRESS_COUNT_EN
  logic [8*NUM_BTNS-1:0] press_q, press_d;

  // Counts advance on the same edge the rise pulse is registered; 8-bit wrap.
  always_comb begin
    press_d = press_q;
    for (int n = 0; n < NUM_BTNS; n++) begin
      if (rise_d[n]) press_d[n*8 +: 8] = press_q[n*8 +: 8] + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) press_q <= '0;
    else       press_q <= press_d;
  end

  assign o_press_cnt = press_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed sequences, a vector table and random stimulus
// checked every cycle against a sliding-window reference model.
module tb_button_debouncer;
  localparam int NB  = 2;
  localparam int DEB = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_btn, o_rise, o_fall;
`ifdef BTN_PRESS_COUNT_EN
  logic [8*NB-1:0] o_press_cnt;
`endif

  button_debouncer #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn),
    .o_btn (o_btn),
    .o_rise(o_rise),
    .o_fall(o_fall)
`ifdef BTN_PRESS_COUNT_EN
    ,
    .o_press_cnt(o_press_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Reference model: a level flips once the last DEB synchronized samples
  // (the raw input delayed two clocks) all disagree with it.
  logic [NB-1:0] raw_h[$];
  logic [NB-1:0] s2_h[$];
  logic [NB-1:0] m_btn = '0, m_rise = '0, m_fall = '0;
  logic [7:0]    m_cnt[NB];
  logic [NB-1:0] m_s2;
  logic          m_all;
  logic          chk_en = 1'b0;

  initial foreach (m_cnt[k]) m_cnt[k] = 8'd0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      raw_h.delete();
      s2_h.delete();
      m_btn  = '0;
      m_rise = '0;
      m_fall = '0;
      foreach (m_cnt[k]) m_cnt[k] = 8'd0;
      chk_en = 1'b1;
    end else begin
      m_s2 = (raw_h.size() >= 2) ? raw_h[raw_h.size()-2] : '0;
      raw_h.push_back(i_btn);
      if (raw_h.size() > 2) void'(raw_h.pop_front());
      s2_h.push_back(m_s2);
      if (s2_h.size() > DEB) void'(s2_h.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int n = 0; n < NB; n++) begin
        if (s2_h.size() == DEB) begin
          m_all = 1'b1;
          foreach (s2_h[j]) if (s2_h[j][n] == m_btn[n]) m_all = 1'b0;
          if (m_all) begin
            m_btn[n] = ~m_btn[n];
            if (m_btn[n]) begin
              m_rise[n] = 1'b1;
              m_cnt[n]  = m_cnt[n] + 8'd1;
            end else begin
              m_fall[n] = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model_btn_rise_fall", {26'd0, o_btn, o_rise, o_fall}, {26'd0, m_btn, m_rise, m_fall});
`ifdef BTN_PRESS_COUNT_EN
      check("model_press_cnt", {16'd0, o_press_cnt}, {16'd0, m_cnt[1], m_cnt[0]});
`endif
    end
  end

  typedef struct {
    logic [NB-1:0] btn;
    int            hold;
    logic [NB-1:0] exp_btn;
  } vec_t;

  vec_t vecs[$];
  int   rises, falls;
  logic [NB-1:0] pat;

  initial begin
    vecs = '{
      '{2'b00, 12, 2'b00}, '{2'b01, 12, 2'b01}, '{2'b10, 7, 2'b01},
      '{2'b10, 5, 2'b10},  '{2'b11, 9, 2'b10},  '{2'b11, 1, 2'b11},
      '{2'b00, 3, 2'b11},  '{2'b11, 3, 2'b11},  '{2'b00, 20, 2'b00}
    };

    // Reset state
    i_rst = 1'b1;
    i_btn = '0;
    tick(3);
    check("reset_btn", o_btn, 2'b00);
    check("reset_rise", o_rise, 2'b00);
    check("reset_fall", o_fall, 2'b00);
    i_rst = 1'b0;
    tick(2);

    // Clean press: level and rise exactly 10 edges after the input step
    i_btn[0] = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check($sformatf("press_btn_e%0d", e), o_btn[0], (e >= 10));
      check($sformatf("press_rise_e%0d", e), o_rise[0], (e == 10));
    end
    tick(3);
    i_btn[0] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check($sformatf("release_fall_e%0d", e), o_fall[0], (e == 10));
    end

    // Bounce every 3 cycles for 30 cycles, then held high
    rises = 0;
    falls = 0;
    for (int c = 0; c < 45; c++) begin
      i_btn[0] = (c < 30) ? ((c / 3) % 2 == 0) : 1'b1;
      tick();
      rises += o_rise[0];
      falls += o_fall[0];
    end
    check("bounce_rises", rises, 1);
    check("bounce_falls", falls, 0);
    check("bounce_level", o_btn[0], 1'b1);

    // Excursion of DEB-1 cycles is filtered; DEB cycles is accepted
    rises = 0;
    i_btn[1] = 1'b1;
    tick(7);
    i_btn[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      rises += o_rise[1] + o_fall[1] + o_btn[1];
    end
    check("short_pulse_quiet", rises, 0);
    rises = 0;
    i_btn[1] = 1'b1;
    tick(8);
    i_btn[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      rises += o_rise[1];
    end
    check("exact_pulse_rise", rises, 1);

    // Simultaneous press, then reset mid-hold, then re-detection
    i_btn = 2'b00;
    tick(14);
    i_btn = 2'b11;
    tick(9);
    check("simul_before", o_btn, 2'b00);
    tick();
    check("simul_btn", o_btn, 2'b11);
    check("simul_rise", o_rise, 2'b11);
    tick(4);
    i_rst = 1'b1;
    tick(2);
    check("rst_mid_btn", {o_btn, o_rise, o_fall}, 6'd0);
    i_rst = 1'b0;
    tick(9);
    check("redetect_before", {o_btn, o_rise}, 4'b0000);
    tick();
    check("redetect_btn", o_btn, 2'b11);
    check("redetect_rise", o_rise, 2'b11);

    // Vector table
    foreach (vecs[v]) begin
      i_btn = vecs[v].btn;
      tick(vecs[v].hold);
      check($sformatf("vec%0d", v), o_btn, vecs[v].exp_btn);
    end

    // Random stimulus with occasional resets; the model checks every cycle
    for (int r = 0; r < 600; r++) begin
      pat = NB'($urandom);
      i_btn = pat;
      if ($urandom_range(0, 40) == 0) begin
        i_rst = 1'b1;
        tick($urandom_range(1, 3));
        i_rst = 1'b0;
      end
      tick($urandom_range(1, 12));
    end

`ifdef BTN_PRESS_COUNT_EN
    i_btn = '0;
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
    for (int p = 0; p < 257; p++) begin
      i_btn[0] = 1'b1;
      tick(12);
      i_btn[0] = 1'b0;
      tick(12);
    end
    check("press_cnt_257", o_press_cnt, 16'h0001);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
